// File: rtl/uart_rx_line_buffer_if.sv
// Read-side byte stream of the UART line buffer: committed bytes are offered
// with valid/ready, and a last flag marks the final byte of each line.
interface uart_rx_line_buffer_if;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_ready;

  modport master (output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/uart_rx_line_buffer.sv
// 16x-oversampling UART receiver feeding a line-oriented FIFO. Only bytes of
// committed lines (EOL, max length or flush) are offered to the reader.
module uart_rx_line_buffer #(
  parameter int unsigned DataBits   = 8,
  parameter int unsigned ParityEna  = 0,
  parameter int unsigned ParityOdd  = 0,
  parameter int unsigned DivWidth   = 16,
  parameter int unsigned BufDepth   = 128,
  parameter int unsigned MaxLineLen = 81,
  parameter logic [7:0]  EolChar    = 8'h0A
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [DivWidth-1:0]             div_i,
  input  logic                            rx_i,
  input  logic                            flush_i,
  uart_rx_line_buffer_if.master           rd,
  output logic [$clog2(BufDepth+1)-1:0]   lines_o,
  output logic [$clog2(BufDepth+1)-1:0]   fill_o,
  output logic                            busy_o,
  output logic                            drop_o,
  output logic                            frame_err_o,
  output logic                            parity_err_o
);

  localparam int CntW = $clog2(BufDepth + 1);
  localparam int PtrW = (BufDepth > 2) ? $clog2(BufDepth) : 1;
  localparam int LenW = $clog2(MaxLineLen + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [1:0]          rxSync_q;
  logic                rxS;
  logic [DivWidth-1:0] tickCnt_q, tickCnt_d, divPrev_q;
  logic                tick;

  state_e     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shift_q, shift_d;
  logic       parBit_q, parBit_d;
  logic       armed_q, armed_d;
  logic       pushReq_q, pushReq_d;
  logic [7:0] pushData_q, pushData_d;
  logic       frameErr_q, frameErr_d;
  logic       parityErr_q, parityErr_d;
  logic       parExp;

  logic [7:0]      mem_q [BufDepth];
  logic            lastMem_q [BufDepth];
  logic [PtrW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, prevWr;
  logic [CntW-1:0] fill_q, fill_d, lines_q, lines_d;
  logic [LenW-1:0] partLen_q, partLen_d;
  logic            drop_q, drop_d;
  logic            full, pushOk, isLast, flushOnly, commit, rdValid, pop, popLast;

  assign rxS    = rxSync_q[1];
  assign parExp = (^shift_q) ^ (ParityOdd != 0);

  // The tick counter restarts whenever the divisor changes so a new rate
  // never inherits a half-finished period of the old one.
  always_comb begin
    tick      = 1'b0;
    tickCnt_d = tickCnt_q + DivWidth'(1);
    if (div_i == '0 || div_i != divPrev_q) begin
      tickCnt_d = '0;
    end else if (tickCnt_q == div_i - DivWidth'(1)) begin
      tick      = 1'b1;
      tickCnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    parBit_d    = parBit_q;
    armed_d     = armed_q | rxS;
    pushReq_d   = 1'b0;
    pushData_d  = pushData_q;
    frameErr_d  = 1'b0;
    parityErr_d = 1'b0;
    if (div_i == '0) begin
      state_d = StIdle;
    end else if (tick) begin
      case (state_q)
        StIdle: begin
          if (!rxS && armed_q) begin
            state_d = StStart;
            phase_d = '0;
          end
        end
        StStart: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd7) begin
            phase_d = '0;
            if (!rxS) begin
              state_d  = StData;
              bitIdx_d = '0;
              shift_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            shift_d[bitIdx_q] = rxS;
            bitIdx_d          = bitIdx_q + 3'd1;
            if (bitIdx_q == 3'(DataBits - 1)) begin
              state_d = (ParityEna != 0) ? StParity : StStop;
            end
          end
        end
        StParity: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            parBit_d = rxS;
            state_d  = StStop;
          end
        end
        StStop: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            state_d = StIdle;
            // A low stop bit disarms start detection until the line idles high.
            if (!rxS) begin
              frameErr_d = 1'b1;
              armed_d    = 1'b0;
            end else if ((ParityEna != 0) && (parBit_q != parExp)) begin
              parityErr_d = 1'b1;
            end else begin
              pushReq_d  = 1'b1;
              pushData_d = shift_q;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign full      = (fill_q == CntW'(BufDepth));
  assign pushOk    = pushReq_q & ~full;
  assign isLast    = (pushData_q == EolChar) || (int'(partLen_q) + 1 == int'(MaxLineLen)) || flush_i;
  assign flushOnly = flush_i & ~pushOk & (partLen_q != '0);
  assign commit    = (pushOk & isLast) | flushOnly;
  assign rdValid   = (lines_q != '0);
  assign pop       = rdValid & rd.rd_ready;
  assign popLast   = pop & lastMem_q[rdPtr_q];
  assign prevWr    = (wrPtr_q == '0) ? PtrW'(BufDepth - 1) : wrPtr_q - PtrW'(1);

  always_comb begin
    drop_d    = pushReq_q & full;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    fill_d    = fill_q;
    lines_d   = lines_q;
    partLen_d = partLen_q;
    if (pushOk) begin
      wrPtr_d   = (wrPtr_q == PtrW'(BufDepth - 1)) ? '0 : wrPtr_q + PtrW'(1);
      partLen_d = isLast ? '0 : partLen_q + LenW'(1);
    end else if (flushOnly) begin
      partLen_d = '0;
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == PtrW'(BufDepth - 1)) ? '0 : rdPtr_q + PtrW'(1);
    end
    if (pushOk && !pop) begin
      fill_d = fill_q + CntW'(1);
    end else if (!pushOk && pop) begin
      fill_d = fill_q - CntW'(1);
    end
    if (commit && !popLast) begin
      lines_d = lines_q + CntW'(1);
    end else if (!commit && popLast) begin
      lines_d = lines_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxSync_q    <= 2'b11;
      tickCnt_q   <= '0;
      divPrev_q   <= '0;
      state_q     <= StIdle;
      phase_q     <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      parBit_q    <= 1'b0;
      armed_q     <= 1'b1;
      pushReq_q   <= 1'b0;
      pushData_q  <= '0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fill_q      <= '0;
      lines_q     <= '0;
      partLen_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      rxSync_q    <= {rxSync_q[0], rx_i};
      tickCnt_q   <= tickCnt_d;
      divPrev_q   <= div_i;
      state_q     <= state_d;
      phase_q     <= phase_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      parBit_q    <= parBit_d;
      armed_q     <= armed_d;
      pushReq_q   <= pushReq_d;
      pushData_q  <= pushData_d;
      frameErr_q  <= frameErr_d;
      parityErr_q <= parityErr_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fill_q      <= fill_d;
      lines_q     <= lines_d;
      partLen_q   <= partLen_d;
      drop_q      <= drop_d;
    end
  end

  // A flush with no byte to carry it retro-tags the newest stored byte.
  always_ff @(posedge clk_i) begin
    if (pushOk) begin
      mem_q[wrPtr_q]     <= pushData_q;
      lastMem_q[wrPtr_q] <= isLast;
    end else if (flushOnly) begin
      lastMem_q[prevWr]  <= 1'b1;
    end
  end

  assign rd.rd_valid  = rdValid;
  assign rd.rd_data   = rdValid ? mem_q[rdPtr_q] : 8'h00;
  assign rd.rd_last   = rdValid & lastMem_q[rdPtr_q];
  assign lines_o      = lines_q;
  assign fill_o       = fill_q;
  assign busy_o       = (state_q != StIdle);
  assign drop_o       = drop_q;
  assign frame_err_o  = frameErr_q;
  assign parity_err_o = parityErr_q;

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Directed bench for uart_rx_line_buffer: two instances (8N1 deep buffer and
// 8E1 eight-entry buffer) checked every cycle against a queue-based line model.
module tb_uart_rx_line_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] div0, div1;
  logic        rx0, rx1, flush0, flush1;
  logic [7:0]  lines0, fill0;
  logic [3:0]  lines1, fill1;
  logic        busy0, drop0, ferr0, perr0;
  logic        busy1, drop1, ferr1, perr1;

  uart_rx_line_buffer_if rdIf0();
  uart_rx_line_buffer_if rdIf1();

  uart_rx_line_buffer #(
    .DataBits(8), .ParityEna(0), .ParityOdd(0), .DivWidth(16),
    .BufDepth(128), .MaxLineLen(81), .EolChar(8'h0A)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .div_i(div0), .rx_i(rx0), .flush_i(flush0),
    .rd(rdIf0), .lines_o(lines0), .fill_o(fill0), .busy_o(busy0),
    .drop_o(drop0), .frame_err_o(ferr0), .parity_err_o(perr0)
  );

  uart_rx_line_buffer #(
    .DataBits(8), .ParityEna(1), .ParityOdd(0), .DivWidth(16),
    .BufDepth(8), .MaxLineLen(8), .EolChar(8'h0A)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .div_i(div1), .rx_i(rx1), .flush_i(flush1),
    .rd(rdIf1), .lines_o(lines1), .fill_o(fill1), .busy_o(busy1),
    .drop_o(drop1), .frame_err_o(ferr1), .parity_err_o(perr1)
  );

  int checks = 0;
  int errors = 0;

  // Line model: each entry is {last, data}; only whole lines are readable.
  logic [8:0] mq0[$];
  logic [8:0] mq1[$];
  int mPart[2];
  int mLines[2];
  bit mSync[2];

  int dropCnt[2], ferrCnt[2], perrCnt[2], busyCnt[2], popCnt[2], lastPopCnt[2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int mFill(input int idx);
    return (idx == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [8:0] mHead(input int idx);
    return (idx == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic modelPush(input int idx, input logic [7:0] b, input bit flush);
    int depth;
    int maxLen;
    bit last;
    depth  = (idx == 0) ? 128 : 8;
    maxLen = (idx == 0) ? 81 : 8;
    if (mFill(idx) >= depth) return;
    last = (b == 8'h0A) || (mPart[idx] + 1 == maxLen) || flush;
    if (idx == 0) mq0.push_back({last, b});
    else          mq1.push_back({last, b});
    if (last) begin
      mLines[idx]++;
      mPart[idx] = 0;
    end else begin
      mPart[idx]++;
    end
  endtask

  task automatic modelFlush(input int idx);
    logic [8:0] e;
    if (mPart[idx] == 0) return;
    if (idx == 0) begin
      e = mq0.pop_back();
      e[8] = 1'b1;
      mq0.push_back(e);
    end else begin
      e = mq1.pop_back();
      e[8] = 1'b1;
      mq1.push_back(e);
    end
    mLines[idx]++;
    mPart[idx] = 0;
  endtask

  task automatic modelPop(input int idx);
    logic [8:0] e;
    if (idx == 0) e = mq0.pop_front();
    else          e = mq1.pop_front();
    if (e[8]) mLines[idx]--;
  endtask

  task automatic modelReset();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      mPart[i]  = 0;
      mLines[i] = 0;
    end
  endtask

  task automatic compareOne(input int idx);
    logic       v, l, rdy;
    logic [7:0] d;
    int         ln, fl;
    logic [8:0] h;
    if (idx == 0) begin
      v = rdIf0.rd_valid; d = rdIf0.rd_data; l = rdIf0.rd_last; rdy = rdIf0.rd_ready;
      ln = int'(lines0); fl = int'(fill0);
    end else begin
      v = rdIf1.rd_valid; d = rdIf1.rd_data; l = rdIf1.rd_last; rdy = rdIf1.rd_ready;
      ln = int'(lines1); fl = int'(fill1);
    end
    checkOutput($sformatf("dut%0d rd_valid", idx), 32'(v), 32'(mLines[idx] > 0));
    checkOutput($sformatf("dut%0d lines", idx), ln, mLines[idx]);
    checkOutput($sformatf("dut%0d fill", idx), fl, mFill(idx));
    if (mLines[idx] > 0) begin
      h = mHead(idx);
      checkOutput($sformatf("dut%0d rd_data", idx), 32'(d), 32'(h[7:0]));
      checkOutput($sformatf("dut%0d rd_last", idx), 32'(l), 32'(h[8]));
      if (rdy) modelPop(idx);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mSync[0]) compareOne(0);
      if (mSync[1]) compareOne(1);
    end
  end

  always @(negedge clk) begin
    if (drop0) dropCnt[0]++;
    if (drop1) dropCnt[1]++;
    if (ferr0) ferrCnt[0]++;
    if (ferr1) ferrCnt[1]++;
    if (perr0) perrCnt[0]++;
    if (perr1) perrCnt[1]++;
    if (busy0) busyCnt[0]++;
    if (busy1) busyCnt[1]++;
    if (rdIf0.rd_valid && rdIf0.rd_ready) begin
      popCnt[0]++;
      if (rdIf0.rd_last) lastPopCnt[0]++;
    end
    if (rdIf1.rd_valid && rdIf1.rd_ready) begin
      popCnt[1]++;
      if (rdIf1.rd_last) lastPopCnt[1]++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setRx(input int idx, input logic v);
    if (idx == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic setFlush(input int idx, input logic v);
    if (idx == 0) flush0 = v;
    else          flush1 = v;
  endtask

  task automatic setReady(input int idx, input logic v);
    if (idx == 0) rdIf0.rd_ready = v;
    else          rdIf1.rd_ready = v;
  endtask

  // Sends one frame; the push is credited to the model once the frame has settled.
  task automatic applyStimulus(input int idx, input logic [7:0] b, input bit stopVal,
                               input bit parFlip, input bit flushAtPush, input bit expectPush);
    int  d;
    int  bitCyc;
    int  stopCyc;
    bit  flushed;
    bit  flushHeld;
    logic bsy;
    d = (idx == 0) ? int'(div0) : int'(div1);
    if (d == 0) d = 2;
    bitCyc  = 16 * d;
    stopCyc = stopVal ? bitCyc : 2 * bitCyc;
    mSync[idx] = 1'b0;
    setRx(idx, 1'b0);
    waitCycles(bitCyc);
    for (int i = 0; i < 8; i++) begin
      setRx(idx, b[i]);
      waitCycles(bitCyc);
    end
    if (idx == 1) begin
      setRx(idx, (^b) ^ parFlip);
      waitCycles(bitCyc);
    end
    setRx(idx, stopVal);
    flushed   = 1'b0;
    flushHeld = 1'b0;
    for (int c = 0; c < stopCyc; c++) begin
      @(posedge clk);
      #1;
      bsy = (idx == 0) ? busy0 : busy1;
      if (flushHeld) begin
        setFlush(idx, 1'b0);
        flushHeld = 1'b0;
      end else if (flushAtPush && !flushed && !bsy) begin
        setFlush(idx, 1'b1);
        flushed   = 1'b1;
        flushHeld = 1'b1;
      end
    end
    setFlush(idx, 1'b0);
    setRx(idx, 1'b1);
    waitCycles(bitCyc);
    if (flushAtPush) checkOutput("flush_timing_found", 32'(flushed), 1);
    if (expectPush) modelPush(idx, b, flushAtPush);
    mSync[idx] = 1'b1;
  endtask

  task automatic drain(input int idx, input int maxCyc);
    setReady(idx, 1'b1);
    for (int c = 0; c < maxCyc && mLines[idx] > 0; c++) waitCycles(1);
    setReady(idx, 1'b0);
    waitCycles(2);
    if (idx == 0) begin
      checkOutput("dut0 drained valid", 32'(rdIf0.rd_valid), 0);
      checkOutput("dut0 drained lines", 32'(lines0), 0);
    end else begin
      checkOutput("dut1 drained valid", 32'(rdIf1.rd_valid), 0);
      checkOutput("dut1 drained lines", 32'(lines1), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fe, pe, dr, bc, pc, lc;
    logic [7:0] msg [10];
    rst_n = 1'b0;
    div0 = 16'd2; div1 = 16'd1;
    rx0 = 1'b1; rx1 = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    rdIf0.rd_ready = 1'b0; rdIf1.rd_ready = 1'b0;
    mSync[0] = 1'b0; mSync[1] = 1'b0;
    modelReset();
    waitCycles(5);

    checkOutput("reset lines0", 32'(lines0), 0);
    checkOutput("reset fill0", 32'(fill0), 0);
    checkOutput("reset valid0", 32'(rdIf0.rd_valid), 0);
    checkOutput("reset busy0", 32'(busy0), 0);
    checkOutput("reset pulses0", 32'({drop0, ferr0, perr0}), 0);
    checkOutput("reset data0", 32'(rdIf0.rd_data), 0);

    rst_n = 1'b1;
    mSync[0] = 1'b1; mSync[1] = 1'b1;
    waitCycles(40);

    // "Hi\n" on the 8N1 instance
    fe = ferrCnt[0]; pe = perrCnt[0]; dr = dropCnt[0];
    applyStimulus(0, 8'h48, 1, 0, 0, 1);
    applyStimulus(0, 8'h69, 1, 0, 0, 1);
    checkOutput("hi partial lines", 32'(lines0), 0);
    applyStimulus(0, 8'h0A, 1, 0, 0, 1);
    checkOutput("hi lines", 32'(lines0), 1);
    checkOutput("hi fill", 32'(fill0), 3);
    checkOutput("hi head data", 32'(rdIf0.rd_data), 32'h48);
    checkOutput("hi head last", 32'(rdIf0.rd_last), 0);
    checkOutput("hi error pulses", ferrCnt[0] - fe + perrCnt[0] - pe + dropCnt[0] - dr, 0);
    lc = lastPopCnt[0]; pc = popCnt[0];
    drain(0, 20);
    checkOutput("hi pops", popCnt[0] - pc, 3);
    checkOutput("hi last pops", lastPopCnt[0] - lc, 1);
    checkOutput("hi fill after", 32'(fill0), 0);

    // 85 x 'A': forced commit at 81, then flush of the 4-byte remainder
    for (int i = 0; i < 85; i++) begin
      applyStimulus(0, 8'h41, 1, 0, 0, 1);
      if (i == 79) checkOutput("len80 lines", 32'(lines0), 0);
      if (i == 80) checkOutput("len81 lines", 32'(lines0), 1);
    end
    checkOutput("len85 fill", 32'(fill0), 85);
    mSync[0] = 1'b0;
    setFlush(0, 1'b1);
    waitCycles(1);
    setFlush(0, 1'b0);
    modelFlush(0);
    mSync[0] = 1'b1;
    waitCycles(2);
    checkOutput("flush lines", 32'(lines0), 2);
    lc = lastPopCnt[0]; pc = popCnt[0];
    drain(0, 200);
    checkOutput("long pops", popCnt[0] - pc, 85);
    checkOutput("long last pops", lastPopCnt[0] - lc, 2);

    // Stop bit low, held low past the frame
    fe = ferrCnt[0]; pe = perrCnt[0];
    applyStimulus(0, 8'h33, 0, 0, 0, 0);
    waitCycles(64);
    checkOutput("frame err pulses", ferrCnt[0] - fe, 1);
    checkOutput("frame err parity pulses", perrCnt[0] - pe, 0);
    checkOutput("frame err fill", 32'(fill0), 0);

    // 5-tick low glitch
    fe = ferrCnt[0]; bc = busyCnt[0];
    mSync[0] = 1'b0;
    setRx(0, 1'b0);
    waitCycles(10);
    setRx(0, 1'b1);
    waitCycles(128);
    mSync[0] = 1'b1;
    checkOutput("glitch start seen", 32'(busyCnt[0] - bc > 0), 1);
    checkOutput("glitch busy", 32'(busy0), 0);
    checkOutput("glitch fill", 32'(fill0), 0);
    checkOutput("glitch errors", ferrCnt[0] - fe, 0);

    // Receiver disabled
    div0 = 16'd0;
    waitCycles(4);
    bc = busyCnt[0];
    applyStimulus(0, 8'h55, 1, 0, 0, 0);
    checkOutput("div0 busy cycles", busyCnt[0] - bc, 0);
    checkOutput("div0 fill", 32'(fill0), 0);
    div0 = 16'd2;
    waitCycles(40);

    // Flush in the push cycle of 0x42
    applyStimulus(0, 8'h41, 1, 0, 0, 1);
    checkOutput("pre flush-push lines", 32'(lines0), 0);
    applyStimulus(0, 8'h42, 1, 0, 1, 1);
    checkOutput("flush-push lines", 32'(lines0), 1);
    checkOutput("flush-push fill", 32'(fill0), 2);
    lc = lastPopCnt[0];
    drain(0, 20);
    checkOutput("flush-push last pops", lastPopCnt[0] - lc, 1);

    // Parity instance: mismatch, then mismatch together with a framing error
    fe = ferrCnt[1]; pe = perrCnt[1];
    applyStimulus(1, 8'h55, 1, 1, 0, 0);
    checkOutput("parity err pulses", perrCnt[1] - pe, 1);
    checkOutput("parity err fill", 32'(fill1), 0);
    fe = ferrCnt[1]; pe = perrCnt[1];
    applyStimulus(1, 8'h55, 0, 1, 0, 0);
    waitCycles(32);
    checkOutput("both err frame pulses", ferrCnt[1] - fe, 1);
    checkOutput("both err parity pulses", perrCnt[1] - pe, 0);

    // Fill the 8-entry buffer with "ABCDEFG\nXY" while the reader stalls
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h0A, 8'h58, 8'h59};
    dr = dropCnt[1];
    for (int i = 0; i < 10; i++) applyStimulus(1, msg[i], 1, 0, 0, 1);
    checkOutput("full fill", 32'(fill1), 8);
    checkOutput("full lines", 32'(lines1), 1);
    checkOutput("full drops", dropCnt[1] - dr, 2);
    pc = popCnt[1];
    drain(1, 30);
    checkOutput("full pops", popCnt[1] - pc, 8);
    setFlush(1, 1'b1);
    waitCycles(1);
    setFlush(1, 1'b0);
    modelFlush(1);
    waitCycles(3);
    checkOutput("empty partial flush lines", 32'(lines1), 0);

    // Reset in mid-frame with a partial line stored
    applyStimulus(0, 8'h41, 1, 0, 0, 1);
    checkOutput("pre reset fill", 32'(fill0), 1);
    mSync[0] = 1'b0; mSync[1] = 1'b0;
    setRx(0, 1'b0);
    waitCycles(96);
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("midreset fill0", 32'(fill0), 0);
    checkOutput("midreset lines0", 32'(lines0), 0);
    checkOutput("midreset busy0", 32'(busy0), 0);
    checkOutput("midreset valid0", 32'(rdIf0.rd_valid), 0);
    checkOutput("midreset pulses0", 32'({drop0, ferr0, perr0}), 0);
    setRx(0, 1'b1);
    waitCycles(3);
    rst_n = 1'b1;
    modelReset();
    mSync[0] = 1'b1; mSync[1] = 1'b1;
    waitCycles(64);
    applyStimulus(0, 8'h42, 1, 0, 0, 1);
    applyStimulus(0, 8'h0A, 1, 0, 0, 1);
    checkOutput("post reset lines", 32'(lines0), 1);
    checkOutput("post reset fill", 32'(fill0), 2);
    checkOutput("post reset head", 32'(rdIf0.rd_data), 32'h42);
    pc = popCnt[0];
    drain(0, 20);
    checkOutput("post reset pops", popCnt[0] - pc, 2);

    waitCycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
